control_pulse_out: RTL and testbench

- Avalon-MM slave output port that drives discrete control lines from the Nios II processor. It is the writer-side counterpart of the edge-capturing input port.
- Provides level control through DATA, SET and CLR registers, plus hardware-timed one-shot pulses of programmable width.
- Raises a completion flag when a pulse ends.
- Sits on the system Avalon bus. out_port goes directly to board control outputs.

---
 rtl/control_pulse_out.sv | 166 ++++++++++++++++
 tb/tb_control_pulse_out.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pulse_out.sv
// Avalon-MM output port: level control via DATA/SET/CLR plus hardware-timed one-shot pulses.
// Define CONTROL_PULSE_OUT_IRQ_EN to add the IRQEN register and the pulse-done interrupt.
module control_pulse_out #(
  parameter int DATA_WIDTH  = 9,
  parameter int CNT_WIDTH   = 16,
  parameter int WIDTH_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [15:0]           writedata,
  output logic [15:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_WIDTH  = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  // Common width covering both the bus and the counter, so CNT_WIDTH may exceed 16.
  localparam int XW = (CNT_WIDTH > 16) ? CNT_WIDTH : 16;
  localparam logic [CNT_WIDTH-1:0] WIDTH_INIT = CNT_WIDTH'(WIDTH_RESET);

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  width_q, width_d;
  logic                  done_q, done_d;
  logic [15:0]           readdata_q, readdata_d;

  logic                  wr;
  logic                  busy;
  logic                  pulseWr;
  logic                  doneSet;
  logic [DATA_WIDTH-1:0] wdData;
  logic [XW-1:0]         wdExt;
  logic [XW-1:0]         widthExt;
  logic [CNT_WIDTH-1:0]  loadCnt;

  assign wr       = chipselect & ~write_n;
  assign busy     = (state_q == ACTIVE);
  assign wdData   = writedata[DATA_WIDTH-1:0];
  assign wdExt    = XW'(writedata);
  assign widthExt = XW'(width_q);
  assign pulseWr  = wr && (address == ADDR_PULSE) && (wdData != '0);
  // A programmed width of zero still yields a one-cycle pulse.
  assign loadCnt  = (width_q == '0) ? '0 : width_q - CNT_WIDTH'(1);
  assign out_port = data_q | pulse_q;
  assign readdata = readdata_q;

  always_comb begin
    data_d  = data_q;
    width_d = width_q;
    if (wr) begin
      case (address)
        ADDR_DATA:  data_d  = wdData;
        ADDR_SET:   data_d  = data_q | wdData;
        ADDR_CLR:   data_d  = data_q & ~wdData;
        ADDR_WIDTH: width_d = wdExt[CNT_WIDTH-1:0];
        default:    ;
      endcase
    end
  end

  // Pulse engine: a nonzero PULSE write (re)loads the countdown; expiry sets done.
  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    count_d = count_q;
    doneSet = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulseWr) begin
          pulse_d = wdData;
          count_d = loadCnt;
          state_d = ACTIVE;
        end
      end
      default: begin
        if (pulseWr) begin
          pulse_d = pulse_q | wdData;
          count_d = loadCnt;
        end else if (count_q == '0) begin
          pulse_d = '0;
          doneSet = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q - CNT_WIDTH'(1);
        end
      end
    endcase
  end

  // Completion beats a simultaneous STATUS write so the event is never lost.
  always_comb begin
    done_d = done_q;
    if (doneSet) begin
      done_d = 1'b1;
    end else if (wr && (address == ADDR_STATUS)) begin
      done_d = 1'b0;
    end
  end

`ifdef CONTROL_PULSE_OUT_IRQ_EN
  localparam logic [2:0] ADDR_IRQEN = 3'd6;
  logic irqEn_q, irqEn_d;

  assign irqEn_d = (wr && (address == ADDR_IRQEN)) ? writedata[0] : irqEn_q;
  assign irq     = done_q & irqEn_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqEn_q <= 1'b0;
    end else begin
      irqEn_q <= irqEn_d;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d = 16'(out_port);
      ADDR_WIDTH:  readdata_d = widthExt[15:0];
      ADDR_PULSE:  readdata_d = 16'(pulse_q);
      ADDR_STATUS: readdata_d = {14'b0, done_q, busy};
`ifdef CONTROL_PULSE_OUT_IRQ_EN
      ADDR_IRQEN:  readdata_d = {15'b0, irqEn_q};
`endif
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      pulse_q    <= '0;
      count_q    <= '0;
      width_q    <= WIDTH_INIT;
      done_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pulse_q    <= pulse_d;
      count_q    <= count_d;
      width_q    <= width_d;
      done_q     <= done_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_control_pulse_out.sv
// Directed self-checking bench for control_pulse_out (default parameters).
// Covers level registers, pulse timing, retrigger, IRQ (per CONTROL_PULSE_OUT_IRQ_EN) and async reset.
module tb_control_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [8:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  control_pulse_out dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Write lands on the next rising edge; returns 1 ns after it with the bus idle.
  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_port !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset_out_port: got 0x%0h, expected 0x000", out_port);
    end
    checks++;
    if (readdata !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_readdata: got 0x%0h, expected 0x0000", readdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_irq: got %b, expected 0", irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL reset_width: got 0x%0h, expected 0x0001", rd);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_status: got 0x%0h, expected 0x0000", rd);
    end
  endtask

  task automatic test_levels();
    logic [15:0] rd;
    do_write(3'd0, 16'h01A5);
    checks++;
    if (out_port !== 9'h1A5) begin
      errors++;
      $display("[TB] FAIL data_write: got 0x%0h, expected 0x1A5", out_port);
    end
    do_read(3'd0, rd);
    checks++;
    if (rd !== 16'h01A5) begin
      errors++;
      $display("[TB] FAIL data_read: got 0x%0h, expected 0x01A5", rd);
    end
    do_write(3'd1, 16'h0002);
    checks++;
    if (out_port !== 9'h1A7) begin
      errors++;
      $display("[TB] FAIL set_write: got 0x%0h, expected 0x1A7", out_port);
    end
    do_read(3'd1, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL set_read_zero: got 0x%0h, expected 0x0000", rd);
    end
    do_write(3'd2, 16'h0004);
    checks++;
    if (out_port !== 9'h1A3) begin
      errors++;
      $display("[TB] FAIL clr_write: got 0x%0h, expected 0x1A3", out_port);
    end
    do_read(3'd0, rd);
    checks++;
    if (rd !== 16'h01A3) begin
      errors++;
      $display("[TB] FAIL data_read_after_clr: got 0x%0h, expected 0x01A3", rd);
    end
    do_write(3'd0, 16'h0000);
  endtask

  task automatic test_pulse_width5();
    logic [15:0] rd;
    logic [15:0] expStatus;
    int hi;
    do_write(3'd3, 16'h0005);
    do_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL width_readback: got 0x%0h, expected 0x0005", rd);
    end
    do_write(3'd4, 16'h0010);
    checks++;
    if (out_port !== 9'h010) begin
      errors++;
      $display("[TB] FAIL pulse5_start: got 0x%0h, expected 0x010", out_port);
    end
    hi = out_port[4] ? 1 : 0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = 3'd5;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (out_port[4]) hi++;
      expStatus = (k <= 5) ? 16'h0001 : 16'h0002;
      checks++;
      if (readdata !== expStatus) begin
        errors++;
        $display("[TB] FAIL pulse5_status_k%0d: got 0x%0h, expected 0x%0h", k, readdata, expStatus);
      end
    end
    chipselect = 1'b0;
    checks++;
    if (hi != 5) begin
      errors++;
      $display("[TB] FAIL pulse5_length: got %0d cycles, expected 5", hi);
    end
  endtask

  task automatic test_width_zero();
    logic [15:0] rd;
    do_write(3'd5, 16'h0000);
    do_write(3'd3, 16'h0000);
    do_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL width0_readback: got 0x%0h, expected 0x0000", rd);
    end
    do_write(3'd4, 16'h0001);
    checks++;
    if (out_port !== 9'h001) begin
      errors++;
      $display("[TB] FAIL width0_pulse_on: got 0x%0h, expected 0x001", out_port);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_port !== 9'h000) begin
      errors++;
      $display("[TB] FAIL width0_pulse_off: got 0x%0h, expected 0x000", out_port);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL width0_done: got 0x%0h, expected 0x0002", rd);
    end
    do_write(3'd4, 16'h0000);
    checks++;
    if (out_port !== 9'h000) begin
      errors++;
      $display("[TB] FAIL zero_pulse_out: got 0x%0h, expected 0x000", out_port);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL zero_pulse_status: got 0x%0h, expected 0x0002", rd);
    end
  endtask

  task automatic test_retrigger();
    logic [15:0] rd;
    int b0;
    int b8;
    do_write(3'd5, 16'h0000);
    do_write(3'd3, 16'h0008);
    do_write(3'd4, 16'h0001);
    b0 = out_port[0] ? 1 : 0;
    b8 = out_port[8] ? 1 : 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 16'h0100;
      end else if (k == 11) begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd5; writedata = 16'h0000;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      @(posedge clk);
      #1;
      if (out_port[0]) b0++;
      if (out_port[8]) b8++;
      if (k == 3) begin
        checks++;
        if (out_port !== 9'h101) begin
          errors++;
          $display("[TB] FAIL retrig_both: got 0x%0h, expected 0x101", out_port);
        end
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    checks++;
    if (b0 != 11) begin
      errors++;
      $display("[TB] FAIL retrig_bit0_len: got %0d cycles, expected 11", b0);
    end
    checks++;
    if (b8 != 8) begin
      errors++;
      $display("[TB] FAIL retrig_bit8_len: got %0d cycles, expected 8", b8);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL retrig_done_wins: got 0x%0h, expected 0x0002", rd);
    end
  endtask

  task automatic test_overlap();
    logic [15:0] rd;
    int bad;
    do_write(3'd5, 16'h0000);
    do_write(3'd3, 16'h0003);
    do_write(3'd0, 16'h0010);
    do_write(3'd4, 16'h0010);
    bad = (out_port !== 9'h010) ? 1 : 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (out_port !== 9'h010) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL overlap_no_change: got %0d deviating samples, expected 0", bad);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL overlap_done: got 0x%0h, expected 0x0002", rd);
    end
    do_write(3'd5, 16'h0000);
    do_write(3'd4, 16'h0020);
    do_write(3'd2, 16'h0010);
    checks++;
    if (out_port !== 9'h020) begin
      errors++;
      $display("[TB] FAIL clr_during_pulse: got 0x%0h, expected 0x020", out_port);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_port !== 9'h000) begin
      errors++;
      $display("[TB] FAIL clr_pulse_end: got 0x%0h, expected 0x000", out_port);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL clr_pulse_done: got 0x%0h, expected 0x0002", rd);
    end
  endtask

  task automatic test_irq();
    logic [15:0] rd;
    do_write(3'd5, 16'h0000);
    do_write(3'd3, 16'h0002);
`ifdef CONTROL_PULSE_OUT_IRQ_EN
    do_write(3'd6, 16'h0001);
    do_read(3'd6, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL irqen_readback: got 0x%0h, expected 0x0001", rd);
    end
    do_write(3'd4, 16'h0002);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_on_done: got %b, expected 1", irq);
    end
    do_write(3'd5, 16'h0000);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_cleared: got %b, expected 0", irq);
    end
    do_write(3'd6, 16'h0000);
    do_write(3'd4, 16'h0002);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_masked: got %b, expected 0", irq);
    end
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL irq_masked_done: got 0x%0h, expected 0x0002", rd);
    end
`else
    do_write(3'd6, 16'h0001);
    do_write(3'd4, 16'h0002);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_tied_low: got %b, expected 0", irq);
    end
    do_read(3'd6, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL addr6_reads_zero: got 0x%0h, expected 0x0000", rd);
    end
`endif
  endtask

  task automatic test_reset_mid_pulse();
    logic [15:0] rd;
    do_write(3'd0, 16'h00FF);
    do_write(3'd3, 16'h0006);
    do_write(3'd4, 16'h0100);
    @(posedge clk);
    #3;
    checks++;
    if (out_port !== 9'h1FF) begin
      errors++;
      $display("[TB] FAIL midpulse_before_reset: got 0x%0h, expected 0x1FF", out_port);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 9'h000) begin
      errors++;
      $display("[TB] FAIL async_reset_out_port: got 0x%0h, expected 0x000", out_port);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL post_reset_status: got 0x%0h, expected 0x0000", rd);
    end
    do_read(3'd3, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL post_reset_width: got 0x%0h, expected 0x0001", rd);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (out_port !== 9'h000) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got 0x%0h, expected 0x000", out_port);
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_pulse_width5();
    test_width_zero();
    test_retrigger();
    test_overlap();
    test_irq();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
